// File: rtl/temporizador_bcd_pkg.sv
// Shared types and limits for the M:SS BCD countdown timer.
// Includes the digit saturation helper used when a new start time is loaded.
package temporizador_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [3:0] MAX_MINS     = 4'd9;
    localparam logic [3:0] MAX_SEC_TENS = 4'd5;
    localparam logic [3:0] MAX_SEC_ONES = 4'd9;

    function automatic logic [3:0] sat_digit(input logic [3:0] digit, input logic [3:0] max_val);
        return (digit > max_val) ? max_val : digit;
    endfunction

endpackage

// File: rtl/temporizador_bcd_if.sv
// Command strobes, load digits and BCD display digits of the countdown timer.
// The timer is the slave; whoever issues commands and consumes the digits is the master.
interface temporizador_bcd_if;
    logic       load;
    logic [3:0] load_mins;
    logic [3:0] load_sec_tens;
    logic [3:0] load_sec_ones;
    logic       start;
    logic       pause;
    logic       clear;
    logic [3:0] mins;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       running;
    logic       done;

    modport master (
        output load, load_mins, load_sec_tens, load_sec_ones, start, pause, clear,
        input  mins, sec_tens, sec_ones, running, done
    );

    modport slave (
        input  load, load_mins, load_sec_tens, load_sec_ones, start, pause, clear,
        output mins, sec_tens, sec_ones, running, done
    );
endinterface

// File: rtl/temporizador_bcd_divisor_tick.sv
// Prescaler counting 0..TICKS_PER_SEC-1 while enabled.
// The tick is high during the terminal count, so the consumer acts on the same edge the count wraps.
module divisor_tick #(
    parameter int TICKS_PER_SEC = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);
    localparam int W = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [W-1:0] LAST = W'(TICKS_PER_SEC - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // next count: clear dominates, hold while disabled
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            if (cnt_q == LAST) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + W'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // count register
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = en_i && !clr_i && (cnt_q == LAST);

endmodule

// File: rtl/temporizador_bcd.sv
// M:SS BCD countdown timer with load, start, pause, resume and clear.
// Digits, running and the one-cycle done pulse all come straight from registers.
module temporizador_bcd
    import temporizador_pkg::*;
#(
    parameter int TICKS_PER_SEC = 50000000
) (
    input  logic              clk,
    input  logic              reset,
    temporizador_bcd_if.slave bus
);
    state_t     state_q, state_d;
    logic [3:0] mins_q, mins_d;
    logic [3:0] tens_q, tens_d;
    logic [3:0] ones_q, ones_d;
    logic       running_q, running_d;
    logic       done_q, done_d;

    logic       tick_s;
    logic       presc_clr_s;
    logic       presc_en_s;
    logic [3:0] dec_mins_s, dec_tens_s, dec_ones_s;
    logic       dec_zero_s;
    logic       time_zero_s;

    assign presc_en_s  = (state_q == ST_RUN);
    assign time_zero_s = (mins_q == 4'd0) && (tens_q == 4'd0) && (ones_q == 4'd0);

    divisor_tick #(.TICKS_PER_SEC(TICKS_PER_SEC)) u_divisor (
        .clk    (clk),
        .reset  (reset),
        .en_i   (presc_en_s),
        .clr_i  (presc_clr_s),
        .tick_o (tick_s)
    );

    // BCD borrow chain; only used in RUN, where the time is never 0:00
    always_comb begin
        dec_mins_s = mins_q;
        dec_tens_s = tens_q;
        dec_ones_s = ones_q - 4'd1;
        if (ones_q == 4'd0) begin
            dec_ones_s = MAX_SEC_ONES;
            if (tens_q == 4'd0) begin
                dec_tens_s = MAX_SEC_TENS;
                dec_mins_s = mins_q - 4'd1;
            end else begin
                dec_tens_s = tens_q - 4'd1;
            end
        end else begin
            dec_ones_s = ones_q - 4'd1;
        end
        dec_zero_s = (dec_mins_s == 4'd0) && (dec_tens_s == 4'd0) && (dec_ones_s == 4'd0);
    end

    // command priority clear > load > start > pause, then counting in RUN
    always_comb begin
        state_d     = state_q;
        mins_d      = mins_q;
        tens_d      = tens_q;
        ones_d      = ones_q;
        done_d      = 1'b0;
        presc_clr_s = 1'b0;
        if (bus.clear) begin
            state_d     = ST_IDLE;
            mins_d      = 4'd0;
            tens_d      = 4'd0;
            ones_d      = 4'd0;
            presc_clr_s = 1'b1;
        end else if (bus.load && (state_q == ST_IDLE || state_q == ST_DONE)) begin
            state_d     = ST_IDLE;
            mins_d      = sat_digit(bus.load_mins, MAX_MINS);
            tens_d      = sat_digit(bus.load_sec_tens, MAX_SEC_TENS);
            ones_d      = sat_digit(bus.load_sec_ones, MAX_SEC_ONES);
            presc_clr_s = 1'b1;
        end else if (bus.start && !time_zero_s && (state_q == ST_IDLE || state_q == ST_PAUSED)) begin
            state_d     = ST_RUN;
            presc_clr_s = (state_q == ST_IDLE);
        end else if (state_q == ST_RUN) begin
            if (tick_s) begin
                mins_d = dec_mins_s;
                tens_d = dec_tens_s;
                ones_d = dec_ones_s;
                if (dec_zero_s) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else if (bus.pause) begin
                    state_d = ST_PAUSED;
                end else begin
                    state_d = ST_RUN;
                end
            end else if (bus.pause) begin
                state_d = ST_PAUSED;
            end else begin
                state_d = ST_RUN;
            end
        end else begin
            state_d = state_q;
        end
        running_d = (state_d == ST_RUN);
    end

    // state, digit and flag registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            mins_q    <= 4'd0;
            tens_q    <= 4'd0;
            ones_q    <= 4'd0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mins_q    <= mins_d;
            tens_q    <= tens_d;
            ones_q    <= ones_d;
            running_q <= running_d;
            done_q    <= done_d;
        end
    end

    assign bus.mins     = mins_q;
    assign bus.sec_tens = tens_q;
    assign bus.sec_ones = ones_q;
    assign bus.running  = running_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_temporizador_bcd.sv
// Directed bench for temporizador_bcd with TICKS_PER_SEC=4.
// Expected display states go through a scoreboard queue and are checked one cycle edge at a time.
module tb_temporizador_bcd;

    typedef struct packed {
        logic [3:0] m;
        logic [3:0] t;
        logic [3:0] o;
        logic       run;
        logic       dn;
    } exp_t;

    logic clk;
    logic reset;
    int   compared;
    int   mismatched;
    exp_t sb_q[$];
    string tag_q[$];

    temporizador_bcd_if bus ();

    temporizador_bcd #(.TICKS_PER_SEC(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int n);
        for (int i = 0; i < n; i++) begin
            cyc();
        end
    endtask

    task automatic expect_state(input string tag, input logic [3:0] m, input logic [3:0] t,
                                input logic [3:0] o, input logic r, input logic d);
        exp_t e;
        e.m = m; e.t = t; e.o = o; e.run = r; e.dn = d;
        sb_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic check_out();
        exp_t  e;
        exp_t  a;
        string tg;
        e = sb_q.pop_front();
        tg = tag_q.pop_front();
        a.m = bus.mins; a.t = bus.sec_tens; a.o = bus.sec_ones;
        a.run = bus.running; a.dn = bus.done;
        compared++;
        assert (a === e) else begin
            mismatched++;
            $error("FAIL %s observed=%0h:%0h%0h run=%0b done=%0b expected=%0h:%0h%0h run=%0b done=%0b",
                   tg, a.m, a.t, a.o, a.run, a.dn, e.m, e.t, e.o, e.run, e.dn);
        end
    endtask

    task automatic chk(input string tag, input logic [3:0] m, input logic [3:0] t,
                       input logic [3:0] o, input logic r, input logic d);
        expect_state(tag, m, t, o, r, d);
        check_out();
    endtask

    task automatic do_load(input logic [3:0] m, input logic [3:0] t, input logic [3:0] o);
        bus.load_mins = m; bus.load_sec_tens = t; bus.load_sec_ones = o;
        bus.load = 1'b1;
        cyc();
        bus.load = 1'b0;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
    endtask

    task automatic do_pause();
        bus.pause = 1'b1;
        cyc();
        bus.pause = 1'b0;
    endtask

    task automatic do_clear();
        bus.clear = 1'b1;
        cyc();
        bus.clear = 1'b0;
    endtask

    initial begin
        compared = 0;
        mismatched = 0;
        reset = 1'b1;
        bus.load = 1'b0; bus.start = 1'b0; bus.pause = 1'b0; bus.clear = 1'b0;
        bus.load_mins = 4'd0; bus.load_sec_tens = 4'd0; bus.load_sec_ones = 4'd0;
        wait_cyc(2);
        reset = 1'b0;
        chk("reset", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);

        // 1: 0:03 counts down to DONE
        do_load(4'd0, 4'd0, 4'd3);  chk("s1_load", 4'd0, 4'd0, 4'd3, 1'b0, 1'b0);
        do_start();                 chk("s1_start", 4'd0, 4'd0, 4'd3, 1'b1, 1'b0);
        wait_cyc(3);                chk("s1_pre_tick", 4'd0, 4'd0, 4'd3, 1'b1, 1'b0);
        wait_cyc(1);                chk("s1_002", 4'd0, 4'd0, 4'd2, 1'b1, 1'b0);
        wait_cyc(4);                chk("s1_001", 4'd0, 4'd0, 4'd1, 1'b1, 1'b0);
        wait_cyc(4);                chk("s1_done", 4'd0, 4'd0, 4'd0, 1'b0, 1'b1);
        wait_cyc(1);                chk("s1_done_pulse_end", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        do_start();                 chk("s1_start_in_done", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);

        // 2: borrow across tens and minutes (load accepted from DONE)
        do_load(4'd1, 4'd0, 4'd0);  chk("s2_load", 4'd1, 4'd0, 4'd0, 1'b0, 1'b0);
        do_start();
        wait_cyc(4);                chk("s2_059", 4'd0, 4'd5, 4'd9, 1'b1, 1'b0);
        wait_cyc(40);               chk("s2_049", 4'd0, 4'd4, 4'd9, 1'b1, 1'b0);
        do_clear();                 chk("s2_clear", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);

        // 3: pause keeps prescaler
        do_load(4'd0, 4'd0, 4'd5);
        do_start();
        wait_cyc(4);                chk("s3_004", 4'd0, 4'd0, 4'd4, 1'b1, 1'b0);
        wait_cyc(1);
        do_pause();                 chk("s3_paused", 4'd0, 4'd0, 4'd4, 1'b0, 1'b0);
        wait_cyc(20);               chk("s3_hold", 4'd0, 4'd0, 4'd4, 1'b0, 1'b0);
        do_start();                 chk("s3_resume", 4'd0, 4'd0, 4'd4, 1'b1, 1'b0);
        wait_cyc(1);                chk("s3_resume_wait", 4'd0, 4'd0, 4'd4, 1'b1, 1'b0);
        wait_cyc(1);                chk("s3_003", 4'd0, 4'd0, 4'd3, 1'b1, 1'b0);
        do_clear();

        // 4: saturation and start at zero
        do_load(4'd12, 4'd7, 4'd15); chk("s4_sat", 4'd9, 4'd5, 4'd9, 1'b0, 1'b0);
        do_load(4'd0, 4'd0, 4'd0);   chk("s4_zero", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        do_start();                  chk("s4_start_zero", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        wait_cyc(5);                 chk("s4_idle_hold", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);

        // 5: clear+start at 2:30, then reset mid-count
        do_load(4'd2, 4'd3, 4'd1);
        do_start();
        wait_cyc(4);                 chk("s5_230", 4'd2, 4'd3, 4'd0, 1'b1, 1'b0);
        bus.clear = 1'b1; bus.start = 1'b1;
        cyc();
        bus.clear = 1'b0; bus.start = 1'b0;
        chk("s5_clear_start", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        wait_cyc(6);                 chk("s5_no_done", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        do_load(4'd0, 4'd2, 4'd0);
        do_start();
        wait_cyc(2);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("s5_reset", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        wait_cyc(5);                 chk("s5_reset_hold", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);

        // 6: load ignored in RUN, accepted in DONE; pause on a tick cycle
        do_load(4'd0, 4'd0, 4'd2);
        do_start();
        wait_cyc(2);
        do_load(4'd0, 4'd0, 4'd9);   chk("s6_load_ignored", 4'd0, 4'd0, 4'd2, 1'b1, 1'b0);
        wait_cyc(1);                 chk("s6_001", 4'd0, 4'd0, 4'd1, 1'b1, 1'b0);
        wait_cyc(4);                 chk("s6_done", 4'd0, 4'd0, 4'd0, 1'b0, 1'b1);
        do_load(4'd0, 4'd0, 4'd7);   chk("s6_load_done", 4'd0, 4'd0, 4'd7, 1'b0, 1'b0);
        do_start();
        wait_cyc(4);                 chk("s6_006", 4'd0, 4'd0, 4'd6, 1'b1, 1'b0);
        wait_cyc(3);
        do_pause();                  chk("s6_pause_on_tick", 4'd0, 4'd0, 4'd5, 1'b0, 1'b0);
        wait_cyc(8);                 chk("s6_pause_hold", 4'd0, 4'd0, 4'd5, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/temporizador_bcd.md
Name: temporizador_bcd

Overview:
BCD countdown timer in M:SS format (0:00 to 9:59). It produces the mins, sec_tens and sec_ones digit buses that feed the 7-segment decoder stage, so it is the source end of that BCD interface. It loads a start time, counts down once per second when started, and supports pause, resume and clear. It flags completion with a one-cycle done pulse and a sticky state.

Parameters:
TICKS_PER_SEC, 50000000, clk cycles per one-second decrement; must be >= 2 (bench uses 4)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high; dominates all other inputs
load  input  1  one-cycle strobe: capture load_* digits as the new time
load_mins  input  4  BCD minutes digit to load
load_sec_tens  input  4  BCD tens-of-seconds digit to load
load_sec_ones  input  4  BCD ones-of-seconds digit to load
start  input  1  one-cycle strobe: begin or resume counting
pause  input  1  one-cycle strobe: suspend counting
clear  input  1  one-cycle strobe: return to 0:00, IDLE
mins  output  4  current minutes digit, BCD 0-9
sec_tens  output  4  current tens-of-seconds digit, BCD 0-5
sec_ones  output  4  current ones-of-seconds digit, BCD 0-9
running  output  1  high while in RUN
done  output  1  one-cycle pulse on the cycle DONE is entered

Behaviour:
- Reset (sync, active-high): state=IDLE, digits=0:00, prescaler=0, running=0, done=0.
- States: IDLE, RUN, PAUSED, DONE. All outputs are registered.
- Input priority within one cycle: reset > clear > load > start > pause.
- clear, from any state: digits=0:00, prescaler=0, state=IDLE.
- load is accepted only in IDLE or DONE, and moves the block to IDLE. It is ignored in RUN and PAUSED.
- Load saturation:
  - load_mins > 9 loads 9.
  - load_sec_tens > 5 loads 5.
  - load_sec_ones > 9 loads 9.
  - Digits update on the cycle after the load strobe.
- start:
  - From IDLE or PAUSED with time != 0:00, go to RUN. From IDLE the prescaler is zeroed first; from PAUSED it keeps its value.
  - With time == 0:00, or in RUN or DONE, start is ignored.
- pause: in RUN, go to PAUSED, holding digits and prescaler. Ignored elsewhere.
- Prescaler:
  - Counts 0..TICKS_PER_SEC-1, only in RUN.
  - Reaching TICKS_PER_SEC-1 raises an internal tick and wraps to 0.
  - First decrement occurs exactly TICKS_PER_SEC cycles after the start strobe is sampled.
- Decrement on tick, BCD borrow chain:
  - sec_ones 0 goes to 9 and borrows from sec_tens.
  - sec_tens 0 goes to 5 and borrows from mins.
  - Example: 1:00 -> 0:59, and 0:10 -> 0:09.
- Reaching zero: when a decrement yields 0:00, the same edge moves state to DONE, sets running=0 and sets done=1 for exactly one cycle. Digits hold at 0:00 and never wrap below zero.
- Simultaneous events:
  - pause on a tick cycle: the decrement is applied, then PAUSED.
  - pause on the cycle that reaches 0:00: DONE wins.
  - clear on a tick cycle: clear wins, no decrement.
- DONE: only load, clear or reset leave it.
- Reset mid-count: the next cycle shows 0:00, IDLE, running=0, and there is no done pulse.

Decomposition:
- Shared package temporizador_pkg:
  - state encoding (IDLE=0, RUN=1, PAUSED=2, DONE=3)
  - constants MAX_MINS=9, MAX_SEC_TENS=5, MAX_SEC_ONES=9
- Sub-module divisor_tick: parameterised prescaler with enable and synchronous clear, producing a one-cycle tick; counter width $clog2(TICKS_PER_SEC).
- Digit saturation and borrow logic stay in the top module.

Test Plan:
All scenarios use TICKS_PER_SEC=4.
1. Reset, then load 0:03, then start. Expect decrements every 4 cycles: 0:02, 0:01, 0:00. done is high for one cycle at 0:00, running falls on that same edge, and the state is DONE.
2. Load 1:00, then start. After 4 cycles expect 0:59. After 40 more cycles expect 0:49 (borrow across sec_tens and mins).
3. Load 0:05, start, pause after 6 cycles (expect 0:04 held for 20 cycles), then start again. The next decrement to 0:03 comes 2 cycles later (prescaler preserved).
4. Load with mins=12, sec_tens=7, sec_ones=15. Expect 9:59 displayed. A start with 0:00 loaded leaves the block in IDLE with running=0.
5. During RUN at 2:30, assert clear and start together. Expect 0:00, IDLE, no done pulse. Assert reset mid-count; expect 0:00, running=0 on the next cycle.
6. Assert load during RUN. Expect it ignored and the count continues. Load accepted in DONE returns the block to IDLE with the new time.
